// File: rtl/iis_pkg.sv
// Shared defaults and FSM encoding for the slave-mode I2S receiver.
package iis_pkg;
   localparam int DATA_W_DEF    = 24;
   localparam int SLOT_BITS_DEF = 32;
   localparam int TIMEOUT_DEF   = 1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } state_t;
endpackage

// File: rtl/iis_sync_edge.sv
// Two-flop synchroniser with a registered rising-edge pulse.
// The pulse appears three clock edges after the pin changes.
module iis_sync_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_in,
   output logic o_rise
);
   logic r_meta;
   logic r_sync;
   logic r_dly;
   logic r_rise;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_dly  <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_meta <= i_in;
         r_sync <= r_meta;
         r_dly  <= r_sync;
         r_rise <= r_sync & ~r_dly;
      end
   end

   assign o_rise = r_rise;
endmodule

// File: rtl/iis_slave_rx.sv
// Slave-mode I2S receiver: oversamples bclk/lrclk and deserialises stereo samples.
// valid/frame_err appear 4 clk_100m cycles after the completing bclk pin rise.
module iis_slave_rx
   import iis_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int SLOT_BITS = SLOT_BITS_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF
) (
   input  logic              clk_100m,
   input  logic              rst,
   input  logic              bclk,
   input  logic              lrclk,
   input  logic              sdata_i,
   output logic [DATA_W-1:0] ldata,
   output logic [DATA_W-1:0] rdata,
   output logic              valid,
   output logic              frame_err,
   output logic              locked
);
   localparam int CNT_W = $clog2(SLOT_BITS + 2);
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SLOT_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_GOOD = CNT_W'(SLOT_BITS);
   localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   logic w_brise;
   logic w_boundary;
   logic w_len_ok;

   // Third stage on lrclk/sdata keeps them aligned with the registered bclk edge pulse.
   logic r_lr_meta, r_lr_sync, r_lr_dly;
   logic r_sd_meta, r_sd_sync, r_sd_dly;

   logic              r_ws_prev;
   logic [CNT_W-1:0]  r_slot_cnt;
   logic [TO_W-1:0]   r_to_cnt;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] r_left_hold;
   logic [DATA_W-1:0] r_ldata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_valid;
   logic              r_frame_err;
   logic              r_locked;
   state_t            r_state;

   iis_sync_edge u_bclk_sync (
      .i_clk  (clk_100m),
      .i_rst  (rst),
      .i_in   (bclk),
      .o_rise (w_brise)
   );

   always_ff @(posedge clk_100m or posedge rst) begin
      if (rst) begin
         r_lr_meta <= 1'b0;
         r_lr_sync <= 1'b0;
         r_lr_dly  <= 1'b0;
         r_sd_meta <= 1'b0;
         r_sd_sync <= 1'b0;
         r_sd_dly  <= 1'b0;
      end else begin
         r_lr_meta <= lrclk;
         r_lr_sync <= r_lr_meta;
         r_lr_dly  <= r_lr_sync;
         r_sd_meta <= sdata_i;
         r_sd_sync <= r_sd_meta;
         r_sd_dly  <= r_sd_sync;
      end
   end

   assign w_boundary = w_brise && (r_lr_dly != r_ws_prev);
   assign w_len_ok   = (r_slot_cnt == CNT_GOOD);

   always_ff @(posedge clk_100m or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ws_prev   <= 1'b0;
         r_slot_cnt  <= '0;
         r_to_cnt    <= '0;
         r_shift     <= '0;
         r_left_hold <= '0;
         r_ldata     <= '0;
         r_rdata     <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_locked    <= 1'b0;
      end else begin
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;

         if (w_brise) begin
            r_to_cnt <= '0;
         end else if (r_to_cnt != TO_LAST) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end

         if (!w_brise && r_to_cnt == TO_LAST) begin
            r_state  <= IDLE;
            r_locked <= 1'b0;
         end else if (w_brise) begin
            r_ws_prev <= r_lr_dly;
            if (w_boundary) begin
               // The boundary bit belongs to the previous slot; it starts the new count at 1.
               r_slot_cnt <= CNT_W'(1);
               r_shift    <= '0;
               case (r_state)
                  IDLE: begin
                     if (!r_lr_dly) r_state <= LEFT;
                  end
                  LEFT: begin
                     if (w_len_ok) begin
                        r_left_hold <= r_shift;
                        r_state     <= RIGHT;
                     end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= IDLE;
                     end
                  end
                  RIGHT: begin
                     if (w_len_ok) begin
                        r_ldata  <= r_left_hold;
                        r_rdata  <= r_shift;
                        r_valid  <= 1'b1;
                        r_locked <= 1'b1;
                        r_state  <= LEFT;
                     end else begin
                        r_frame_err <= 1'b1;
                        r_locked    <= 1'b0;
                        r_state     <= IDLE;
                     end
                  end
                  default: r_state <= IDLE;
               endcase
            end else begin
               if (r_slot_cnt != CNT_SAT) r_slot_cnt <= r_slot_cnt + 1'b1;
               if (r_slot_cnt <= CNT_DATA) r_shift <= {r_shift[DATA_W-2:0], r_sd_dly};
            end
         end
      end
   end

   assign ldata     = r_ldata;
   assign rdata     = r_rdata;
   assign valid     = r_valid;
   assign frame_err = r_frame_err;
   assign locked    = r_locked;
endmodule
